// File: rtl/dreg_decouple_if.sv
// Valid/ready channel carrying a DW-bit payload.
// master drives data/valid, slave drives ready.
interface dreg_decouple_if #(
   parameter int unsigned DW = 16
) ();

   logic [DW-1:0] data;
   logic          valid;
   logic          ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/dreg_decouple.sv
// Ready-path decoupler: register-file FIFO whose din.ready comes only from a flop,
// so the consumer's ready never reaches the producer combinationally.
module dreg_decouple #(
   parameter int unsigned DIN   = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   dreg_decouple_if.slave             din,
   dreg_decouple_if.master            dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DIN-1:0] mem_q [DEPTH];
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           ready_q, ready_d;
   logic           empty, full;
   logic           wr_en, rd_en;

   // The MSB of each pointer is the wrap bit that separates full from empty.
   assign empty = (rd_ptr_q == wr_ptr_q);
   assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

   assign wr_en = din.valid & ready_q & ~full;
   assign rd_en = ~empty & dout.ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + CW'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - CW'(1);
      end
      // Registered ready: a read while full frees space only from the next cycle.
      ready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Storage is intentionally not reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din.data;
      end
   end

   assign din.ready  = ready_q;
   assign dout.valid = ~empty;
   assign dout.data  = mem_q[rd_ptr_q[AW-1:0]];
   assign count      = count_q;

endmodule

// File: tb/tb_dreg_decouple.sv
// Bench for dreg_decouple: directed checks on a DEPTH=2 instance, randomized
// traffic against a queue model on a DEPTH=4 instance, then mid-stream reset.
module tb_dreg_decouple;

   localparam int unsigned DW      = 16;
   localparam int unsigned DEPTH_A = 2;
   localparam int unsigned DEPTH_B = 4;
   localparam int unsigned NWORDS  = 1000;

   logic clk;
   logic rst;
   logic [1:0] count_a;
   logic [2:0] count_b;

   dreg_decouple_if #(.DW(DW)) a_in  ();
   dreg_decouple_if #(.DW(DW)) a_out ();
   dreg_decouple_if #(.DW(DW)) b_in  ();
   dreg_decouple_if #(.DW(DW)) b_out ();

   dreg_decouple #(.DIN(DW), .DEPTH(DEPTH_A)) u_dut_a (
      .clk   (clk),
      .rst   (rst),
      .din   (a_in),
      .dout  (a_out),
      .count (count_a)
   );

   dreg_decouple #(.DIN(DW), .DEPTH(DEPTH_B)) u_dut_b (
      .clk   (clk),
      .rst   (rst),
      .din   (b_in),
      .dout  (b_out),
      .count (count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [DW-1:0] q[$];
   logic          exp_rdy;
   logic          dv, dr, wr, rd;
   int unsigned   wr_word, rd_words, cyc;

   initial begin
      rst         = 1'b0;
      a_in.valid  = 1'b0;
      a_in.data   = '0;
      a_out.ready = 1'b0;
      b_in.valid  = 1'b0;
      b_in.data   = '0;
      b_out.ready = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_eq("rst_in_ready", a_in.ready, 0);
         check_eq("rst_out_valid", a_out.valid, 0);
         check_eq("rst_count", count_a, 0);
      end
      rst = 1'b1;
      #1;
      check_eq("rel_ready_before_edge", a_in.ready, 0);
      @(negedge clk);
      #1;
      check_eq("rel_ready_a", a_in.ready, 1);
      check_eq("rel_ready_b", b_in.ready, 1);

      // Single word into empty FIFO, no bypass
      @(negedge clk);
      a_in.valid  = 1'b1;
      a_in.data   = 16'h1234;
      a_out.ready = 1'b1;
      #1;
      check_eq("single_no_bypass", a_out.valid, 0);
      @(negedge clk);
      a_in.valid = 1'b0;
      #1;
      check_eq("single_valid", a_out.valid, 1);
      check_eq("single_data", a_out.data, 16'h1234);
      check_eq("single_count1", count_a, 1);
      @(negedge clk);
      #1;
      check_eq("single_drained_valid", a_out.valid, 0);
      check_eq("single_count0", count_a, 0);

      // Fill DEPTH=2 with A, B while C waits
      @(negedge clk);
      a_out.ready = 1'b0;
      a_in.valid  = 1'b1;
      a_in.data   = 16'h000A;
      #1;
      check_eq("fill_ready0", a_in.ready, 1);
      @(negedge clk);
      a_in.data = 16'h000B;
      #1;
      check_eq("fill_count1", count_a, 1);
      check_eq("fill_head_a", a_out.data, 16'h000A);
      @(negedge clk);
      a_in.data = 16'h000C;
      #1;
      check_eq("full_count", count_a, 2);
      check_eq("full_ready", a_in.ready, 0);
      @(negedge clk);
      #1;
      check_eq("full_hold_count", count_a, 2);
      check_eq("full_hold_ready", a_in.ready, 0);
      check_eq("full_hold_head", a_out.data, 16'h000A);

      // Drain while C is offered: one-cycle ready bubble
      a_out.ready = 1'b1;
      #1;
      check_eq("no_comb_ready_path", a_in.ready, 0);
      @(negedge clk);
      #1;
      check_eq("drain1_count", count_a, 1);
      check_eq("drain1_ready", a_in.ready, 1);
      check_eq("drain1_head_b", a_out.data, 16'h000B);
      @(negedge clk);
      a_in.valid = 1'b0;
      #1;
      check_eq("drain2_count", count_a, 1);
      check_eq("drain2_valid", a_out.valid, 1);
      check_eq("drain2_head_c", a_out.data, 16'h000C);
      @(negedge clk);
      #1;
      check_eq("drain3_valid", a_out.valid, 0);
      check_eq("drain3_count", count_a, 0);
      a_out.ready = 1'b0;

      // Randomized traffic on DEPTH=4 against a queue model
      exp_rdy  = 1'b1;
      wr_word  = 0;
      rd_words = 0;
      cyc      = 0;
      while (rd_words < NWORDS && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         dv = (wr_word < NWORDS) && ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 2) != 0);
         b_in.valid  = dv;
         b_in.data   = wr_word[DW-1:0];
         b_out.ready = dr;
         #1;
         check_eq("rnd_ready", b_in.ready, exp_rdy);
         check_eq("rnd_valid", b_out.valid, q.size() != 0);
         check_eq("rnd_count", count_b, q.size());
         if (q.size() != 0) check_eq("rnd_data", b_out.data, q[0]);
         wr = dv && exp_rdy;
         rd = (q.size() != 0) && dr;
         @(posedge clk);
         if (rd) begin
            void'(q.pop_front());
            rd_words++;
         end
         if (wr) begin
            q.push_back(wr_word[DW-1:0]);
            wr_word++;
         end
         exp_rdy = (q.size() != DEPTH_B);
      end
      check_eq("rnd_words_done", rd_words, NWORDS);

      // Reset with three words buffered
      @(negedge clk);
      b_out.ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b_in.valid = 1'b1;
         b_in.data  = 16'h0100 + 16'(i);
         @(negedge clk);
      end
      b_in.valid = 1'b0;
      #1;
      check_eq("mid_count3", count_b, 3);
      check_eq("mid_head", b_out.data, 16'h0100);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_valid", b_out.valid, 0);
      check_eq("mid_rst_count", count_b, 0);
      check_eq("mid_rst_ready", b_in.ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      b_out.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check_eq("post_rst_no_stale", b_out.valid, 0);
      end
      check_eq("post_rst_ready", b_in.ready, 1);
      b_in.valid = 1'b1;
      b_in.data  = 16'h55AA;
      @(negedge clk);
      b_in.valid = 1'b0;
      #1;
      check_eq("post_rst_valid", b_out.valid, 1);
      check_eq("post_rst_data", b_out.data, 16'h55AA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
